// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline stage registers: skid-buffer occupancy
// states and the EXE->MEM payload layout.
package arm_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEST_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [DATA_W_DEF-1:0] alu_res;
    logic [DATA_W_DEF-1:0] val_rm;
    logic [DEST_W_DEF-1:0] dest;
  } exe_mem_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry elastic register: a main entry driving the output and a
// skid entry that absorbs one extra word so in_ready never depends on out_ready.
module pipe_skid_buf
  import arm_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  skid_state_e  state_q, nxt_state;
  logic         rdy_q;
  logic [W-1:0] main_q, skid_q;
  logic         in_xfer, out_xfer;
  logic         ld_main_in, ld_main_skid, ld_skid;

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid && rdy_q;
  assign out_xfer  = out_valid && out_ready;
  assign occ       = {1'b0, state_q != ST_EMPTY} + {1'b0, state_q == ST_TWO};

  always_comb begin
    nxt_state    = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      nxt_state = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_xfer) begin
          nxt_state  = ST_ONE;
          ld_main_in = 1'b1;
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            ld_main_in = 1'b1;
          end else if (in_xfer) begin
            nxt_state = ST_TWO;
            ld_skid   = 1'b1;
          end else if (out_xfer) begin
            nxt_state = ST_EMPTY;
          end
        end
        ST_TWO: if (out_xfer) begin
          nxt_state    = ST_ONE;
          ld_main_skid = 1'b1;
        end
        default: nxt_state = ST_EMPTY;
      endcase
    end
  end

  // ready is registered from the next state so it is a pure flop output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= nxt_state;
      rdy_q   <= (nxt_state != ST_TWO);
      if (ld_main_in)        main_q <= in_data;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register: packs the EXE payload into a skid buffer,
// gates the MEM control bits with valid and counts back-pressure cycles.
module exe_mem_skid_reg
  import arm_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEST_W = DEST_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              VALID_EXE,
  output logic              READY_EXE,
  input  logic              WB_EN_EXE,
  input  logic              MEM_R_EN_EXE,
  input  logic              MEM_W_EN_EXE,
  input  logic [DATA_W-1:0] ALU_RES_EXE,
  input  logic [DATA_W-1:0] VAL_RM_EXE,
  input  logic [DEST_W-1:0] DEST_EXE,
  output logic              VALID_MEM,
  input  logic              READY_MEM,
  output logic              WB_EN_MEM,
  output logic              MEM_R_EN_MEM,
  output logic              MEM_W_EN_MEM,
  output logic [DATA_W-1:0] ALU_RES_MEM,
  output logic [DATA_W-1:0] VAL_RM_MEM,
  output logic [DEST_W-1:0] DEST_MEM,
  input  logic              FLUSH,
  output logic [1:0]        OCC,
  output logic [CNT_W-1:0]  STALL_CNT
);

  localparam int PW = 3 + 2 * DATA_W + DEST_W;

  logic [PW-1:0]    pay_in, pay_out;
  logic             wb_raw, rd_raw, wr_raw;
  logic [CNT_W-1:0] stall_cnt_q;

  // field order matches exe_mem_t
  assign pay_in = {WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, ALU_RES_EXE, VAL_RM_EXE, DEST_EXE};
  assign {wb_raw, rd_raw, wr_raw, ALU_RES_MEM, VAL_RM_MEM, DEST_MEM} = pay_out;

  pipe_skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (FLUSH),
    .in_valid  (VALID_EXE),
    .in_ready  (READY_EXE),
    .in_data   (pay_in),
    .out_valid (VALID_MEM),
    .out_ready (READY_MEM),
    .out_data  (pay_out),
    .occ       (OCC)
  );

  assign WB_EN_MEM    = VALID_MEM & wb_raw;
  assign MEM_R_EN_MEM = VALID_MEM & rd_raw;
  assign MEM_W_EN_MEM = VALID_MEM & wr_raw;

  // flush leaves the counter alone; it only saturates
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (VALID_MEM && !READY_MEM && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Bench for exe_mem_skid_reg: directed scenarios plus random traffic checked
// every cycle against a queue-based model of the two-entry register.
module tb_exe_mem_skid_reg;
  import arm_pipe_pkg::*;

  logic        clk, rst;
  logic        valid_exe, wb_en_exe, mem_r_en_exe, mem_w_en_exe, ready_mem, flush;
  logic [31:0] alu_res_exe, val_rm_exe;
  logic [3:0]  dest_exe;

  logic        ready_exe, valid_mem, wb_en_mem, mem_r_en_mem, mem_w_en_mem;
  logic [31:0] alu_res_mem, val_rm_mem;
  logic [3:0]  dest_mem;
  logic [1:0]  occ;
  logic [15:0] stall_cnt;

  logic        s_ready_exe, s_valid_mem, s_wb, s_rd, s_wr;
  logic [31:0] s_alu, s_rm;
  logic [3:0]  s_dest;
  logic [1:0]  s_occ;
  logic [3:0]  s_stall;

  exe_mem_skid_reg dut (
    .clk(clk), .rst(rst),
    .VALID_EXE(valid_exe), .READY_EXE(ready_exe),
    .WB_EN_EXE(wb_en_exe), .MEM_R_EN_EXE(mem_r_en_exe), .MEM_W_EN_EXE(mem_w_en_exe),
    .ALU_RES_EXE(alu_res_exe), .VAL_RM_EXE(val_rm_exe), .DEST_EXE(dest_exe),
    .VALID_MEM(valid_mem), .READY_MEM(ready_mem),
    .WB_EN_MEM(wb_en_mem), .MEM_R_EN_MEM(mem_r_en_mem), .MEM_W_EN_MEM(mem_w_en_mem),
    .ALU_RES_MEM(alu_res_mem), .VAL_RM_MEM(val_rm_mem), .DEST_MEM(dest_mem),
    .FLUSH(flush), .OCC(occ), .STALL_CNT(stall_cnt)
  );

  exe_mem_skid_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .VALID_EXE(valid_exe), .READY_EXE(s_ready_exe),
    .WB_EN_EXE(wb_en_exe), .MEM_R_EN_EXE(mem_r_en_exe), .MEM_W_EN_EXE(mem_w_en_exe),
    .ALU_RES_EXE(alu_res_exe), .VAL_RM_EXE(val_rm_exe), .DEST_EXE(dest_exe),
    .VALID_MEM(s_valid_mem), .READY_MEM(ready_mem),
    .WB_EN_MEM(s_wb), .MEM_R_EN_MEM(s_rd), .MEM_W_EN_MEM(s_wr),
    .ALU_RES_MEM(s_alu), .VAL_RM_MEM(s_rm), .DEST_MEM(s_dest),
    .FLUSH(flush), .OCC(s_occ), .STALL_CNT(s_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the instructions held, oldest first; the output shows the oldest,
  // or the last one shown when nothing is held.
  exe_mem_t    q[$];
  exe_mem_t    last;
  int unsigned m_stall;

  always @(posedge clk) begin
    exe_mem_t cur;
    bit do_in, do_out;
    cur = '{wb_en: wb_en_exe, mem_r_en: mem_r_en_exe, mem_w_en: mem_w_en_exe,
            alu_res: alu_res_exe, val_rm: val_rm_exe, dest: dest_exe};
    if (rst) begin
      q.delete();
      last    = '0;
      m_stall = 0;
    end else begin
      if (q.size() > 0 && !ready_mem) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        do_out = (q.size() > 0) && ready_mem;
        do_in  = valid_exe && (q.size() < 2);
        if (do_out) void'(q.pop_front());
        if (do_in)  q.push_back(cur);
      end
      if (q.size() > 0) last = q[0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit v;
      v = (q.size() > 0);
      chk("valid_mem", valid_mem, v);
      chk("ready_exe", ready_exe, q.size() < 2);
      chk("occ", occ, q.size());
      chk("wb_en_mem", wb_en_mem, v & last.wb_en);
      chk("mem_r_en_mem", mem_r_en_mem, v & last.mem_r_en);
      chk("mem_w_en_mem", mem_w_en_mem, v & last.mem_w_en);
      chk("alu_res_mem", alu_res_mem, last.alu_res);
      chk("val_rm_mem", val_rm_mem, last.val_rm);
      chk("dest_mem", dest_mem, last.dest);
      chk("stall_cnt", stall_cnt, (m_stall > 65535) ? 65535 : m_stall);
      chk("sat_stall_cnt", s_stall, (m_stall > 15) ? 15 : m_stall);
      chk("sat_occ", s_occ, q.size());
    end
  end

  task automatic rand_payload();
    wb_en_exe    = 1'($urandom);
    mem_r_en_exe = 1'($urandom);
    mem_w_en_exe = 1'($urandom);
    alu_res_exe  = $urandom;
    val_rm_exe   = $urandom;
    dest_exe     = 4'($urandom);
  endtask

  task automatic send(input logic [31:0] alu, input logic w);
    rand_payload();
    valid_exe    = 1'b1;
    alu_res_exe  = alu;
    mem_w_en_exe = w;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ready_mem = 1'($urandom);
    valid_exe = 1'($urandom); rand_payload();

    // Reset with random inputs for two cycles
    step();
    chk_en = 1;
    valid_exe = 1'($urandom); rand_payload(); flush = 1'($urandom);
    step();
    chk("rst valid_mem", valid_mem, 0);
    chk("rst occ", occ, 0);
    chk("rst ready_exe", ready_exe, 1);
    chk("rst stall", stall_cnt, 0);
    chk("rst outputs", {wb_en_mem, mem_r_en_mem, mem_w_en_mem, alu_res_mem, val_rm_mem, dest_mem}, 0);
    rst = 1'b0; flush = 1'b0; valid_exe = 1'b0;

    // Streaming
    ready_mem = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(32'h10 + i, 1'b0);
      step();
      chk("stream alu", alu_res_mem, 32'h10 + i);
      chk("stream occ", occ, 1);
      chk("stream valid", valid_mem, 1);
    end
    valid_exe = 1'b0;
    step();

    // Back-pressure: A, B held, C waits at the input
    ready_mem = 1'b0;
    send(32'hAAAA0000, 1'b0);
    step();
    chk("bp occ A", occ, 1);
    send(32'hBBBB0000, 1'b0);
    step();
    chk("bp occ AB", occ, 2);
    chk("bp ready_exe", ready_exe, 0);
    send(32'hCCCC0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp hold A", alu_res_mem, 32'hAAAA0000);
      chk("bp hold occ", occ, 2);
    end
    chk("bp stall", stall_cnt, 4);
    ready_mem = 1'b1;
    step();
    chk("bp out B", alu_res_mem, 32'hBBBB0000);
    step();
    chk("bp out C", alu_res_mem, 32'hCCCC0000);
    valid_exe = 1'b0;
    step();
    chk("bp drained", valid_mem, 0);
    chk("bp data held", alu_res_mem, 32'hCCCC0000);

    // Flush in TWO with simultaneous input and output
    ready_mem = 1'b0;
    send(32'h11110000, 1'b1);
    step();
    send(32'h22220000, 1'b1);
    step();
    chk("fl occ", occ, 2);
    send(32'h33330000, 1'b1);
    flush = 1'b1; ready_mem = 1'b1;
    step();
    chk("fl valid", valid_mem, 0);
    chk("fl occ0", occ, 0);
    chk("fl mem_w", mem_w_en_mem, 0);
    chk("fl ready", ready_exe, 1);
    flush = 1'b0; valid_exe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl gone", valid_mem, 0);
      chk("fl data held", alu_res_mem, 32'h11110000);
    end

    // Reset in the middle of a stall in TWO
    ready_mem = 1'b0;
    send(32'h44440000, 1'b1);
    step();
    send(32'h55550000, 1'b1);
    step();
    chk("rs occ", occ, 2);
    rst = 1'b1; ready_mem = 1'b1; flush = 1'b1;
    step();
    chk("rs occ0", occ, 0);
    chk("rs valid", valid_mem, 0);
    chk("rs alu", alu_res_mem, 0);
    chk("rs stall", stall_cnt, 0);
    rst = 1'b0; flush = 1'b0; valid_exe = 1'b0;
    step();
    chk("rs lost", valid_mem, 0);

    // Saturation of the 4-bit counter
    ready_mem = 1'b0;
    send(32'h66660000, 1'b0);
    step();
    valid_exe = 1'b0;
    repeat (20) step();
    chk("sat 4bit", s_stall, 15);
    chk("sat 16bit", stall_cnt, 20);
    ready_mem = 1'b1;
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_payload();
      valid_exe = 1'($urandom);
      ready_mem = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 127) == 0);
      step();
    end

    chk_en = 0;
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/exe_mem_skid_reg.md
EXE_MEM_SKID_REG -- requirements
Module: exe_mem_skid_reg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` (rising edge) and `rst`.
REQ-002 The block SHALL have the following parameters:
- `DATA_W`, default 32, width of the ALU result and Rm value.
- `DEST_W`, default 4, width of the register-file destination index.
- `CNT_W`, default 16, width of the stall counter.
REQ-003 The block SHALL have the following ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `VALID_EXE`  in  1  EXE offers an instruction.
- `READY_EXE`  out  1  block accepts the instruction this cycle.
- `WB_EN_EXE`, `MEM_R_EN_EXE`, `MEM_W_EN_EXE`  in  1 each  control bits.
- `ALU_RES_EXE`, `VAL_RM_EXE`  in  `DATA_W` each  data payload.
- `DEST_EXE`  in  `DEST_W`  destination register index.
- `VALID_MEM`  out  1  MEM-side entry is valid.
- `READY_MEM`  in  1  MEM consumes the entry this cycle.
- `WB_EN_MEM`, `MEM_R_EN_MEM`, `MEM_W_EN_MEM`  out  1 each  control bits, gated by `VALID_MEM`.
- `ALU_RES_MEM`, `VAL_RM_MEM`  out  `DATA_W` each  data payload.
- `DEST_MEM`  out  `DEST_W`  destination register index.
- `FLUSH`  in  1  discard all held instructions (branch taken).
- `OCC`  out  2  entries held: 0, 1 or 2.
- `STALL_CNT`  out  `CNT_W`  saturating count of back-pressure cycles.

Function
REQ-004 The block SHALL be a two-entry elastic pipeline register with a main entry that drives the `*_MEM` outputs and one skid entry.
REQ-005 An input transfer SHALL occur when `VALID_EXE && READY_EXE`; an output transfer SHALL occur when `VALID_MEM && READY_MEM`.
REQ-006 `READY_EXE` SHALL come directly from a flop and equal NOT skid-valid, with no combinational path from `READY_MEM`.
REQ-007 The state machine SHALL have three states, EMPTY (`OCC`=0), ONE (`OCC`=1) and TWO (`OCC`=2), with these transitions:
- EMPTY: input transfer -> ONE, main loaded.
- ONE: input and output transfer -> ONE, main reloaded.
- ONE: input only -> TWO, skid loaded.
- ONE: output only -> EMPTY.
- ONE: neither -> ONE, main held.
- TWO: output transfer -> ONE, main loaded from skid.
- TWO: no output transfer -> TWO, both entries held.
REQ-008 Latency SHALL be exactly one cycle: an instruction accepted at edge N appears on `*_MEM` with `VALID_MEM`=1 after edge N.
REQ-009 Throughput SHALL be one instruction per cycle while `READY_MEM`=1.
REQ-010 Order SHALL be preserved, and no instruction SHALL be dropped or duplicated.
REQ-011 `WB_EN_MEM`, `MEM_R_EN_MEM` and `MEM_W_EN_MEM` SHALL be 0 whenever `VALID_MEM`=0.
REQ-012 Data outputs SHALL hold their last value while `VALID_MEM`=0.
REQ-013 When `FLUSH`=1 at an edge:
- both valid bits SHALL be cleared and the state SHALL go to EMPTY;
- `FLUSH` SHALL take priority over simultaneous input and output transfers;
- the instruction offered that cycle SHALL be discarded;
- `READY_EXE` SHALL be 1 in the following cycle.
REQ-014 `STALL_CNT` SHALL increment by 1 on every edge where `VALID_MEM`=1 and `READY_MEM`=0.
REQ-015 `STALL_CNT` SHALL saturate at 2^`CNT_W`-1 and SHALL not be cleared by `FLUSH`.
REQ-016 Payload bits SHALL be copied without modification; there is no arithmetic on them.
REQ-017 `OCC` SHALL equal main-valid + skid-valid.

Reset
REQ-018 On a rising `clk` edge with `rst`=1, the block SHALL drive:
- all valid bits to 0 and the state to EMPTY;
- all payload registers to 0;
- `STALL_CNT` to 0.
REQ-019 Reset SHALL override `FLUSH` and all transfers, including a reset in the middle of a stall while in TWO.
REQ-020 After reset, `READY_EXE` SHALL be 1, `VALID_MEM` 0, `OCC` 0 and all `*_MEM` outputs 0.

Structure
REQ-021 Package `arm_pipe_pkg` SHALL hold:
- the state enum (EMPTY, ONE, TWO);
- a packed payload struct `exe_mem_t` {wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest}, sized from the package constants `DATA_W_DEF` and `DEST_W_DEF`.
REQ-022 Sub-module `pipe_skid_buf` SHALL implement the generic handshake, the two entries, `FLUSH` and `OCC` over a `W`-bit payload.
REQ-023 `exe_mem_skid_reg` SHALL pack and unpack the payload, apply the control gating and contain the stall counter.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset: assert `rst` 2 cycles with random inputs -> `VALID_MEM`=0, `OCC`=0, `READY_EXE`=1, `STALL_CNT`=0, all outputs 0.
- Streaming: `READY_MEM`=1, 8 back-to-back instructions with `ALU_RES_EXE`=0x10..0x17 -> same values on `ALU_RES_MEM`, one per cycle, 1-cycle latency, `OCC`=1 throughout.
- Back-pressure: `READY_MEM`=0 while sending A=0xAAAA0000 then B=0xBBBB0000 -> `OCC`=2, `READY_EXE`=0; C held at the input is not accepted; after `READY_MEM`=1 the outputs are A, B, C in order; `STALL_CNT` equals the stalled cycles.
- Flush: in TWO, assert `FLUSH` together with `VALID_EXE`=1 and `READY_MEM`=1 -> next cycle `VALID_MEM`=0, `OCC`=0, `MEM_W_EN_MEM`=0, and the flushed instructions never appear.
- Saturation: `CNT_W`=4, hold `VALID_MEM`=1, `READY_MEM`=0 for 20 cycles -> `STALL_CNT`=15.
- Reset mid-stall: `rst` in TWO -> EMPTY next cycle and the held entries are lost.
